// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 receiver.
package rs232_pkg;

  localparam int unsigned RS232_DATA_BITS    = 8;
  localparam int unsigned RS232_OVERSAMPLING = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rs232_state_e;

endpackage

// File: rtl/rs232_rx_filter.sv
// Input conditioning for rxd: 2-FF synchronizer followed by a tick-driven
// 2-bit saturating majority counter with hysteresis.
module rs232_rx_filter (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rxd,
  output logic rx_f
);

  logic       sync1_q, sync2_q;
  logic [1:0] cnt_q, cnt_d;
  logic       rx_f_q, rx_f_d;

  // Output only moves at the saturation points, holding in between.
  always_comb begin
    cnt_d  = cnt_q;
    rx_f_d = rx_f_q;
    if (baud_tick) begin
      if (sync2_q && (cnt_q != 2'd3)) begin
        cnt_d = cnt_q + 2'd1;
      end else if (!sync2_q && (cnt_q != 2'd0)) begin
        cnt_d = cnt_q - 2'd1;
      end
      if (cnt_d == 2'd3) begin
        rx_f_d = 1'b1;
      end else if (cnt_d == 2'd0) begin
        rx_f_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= 2'd3;
      rx_f_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      rx_f_q  <= rx_f_d;
    end
  end

  assign rx_f = rx_f_q;

endmodule

// File: rtl/rs232_rx.sv
// Oversampling RS-232 receiver: 1 start, 8 data LSB first, 1 stop bit.
// Optional even parity bit when RS232_RX_PARITY_EN is defined.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int unsigned OVERSAMPLING = RS232_OVERSAMPLING,
  parameter int unsigned IDLE_BITS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       frame_error,
  output logic       busy,
  output logic       idle
);

  localparam int unsigned CNT_W    = $clog2(OVERSAMPLING);
  localparam int unsigned BIT_W    = $clog2(RS232_DATA_BITS);
  localparam int unsigned IDLE_MAX = IDLE_BITS * OVERSAMPLING;
  localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);

  logic rx_f;

  rs232_rx_filter u_filter (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rxd       (rxd),
    .rx_f      (rx_f)
  );

  rs232_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 frame_error_q, frame_error_d;
  logic                 armed_q, armed_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 idle_q, idle_d;
  logic                 par_ok_c;
  logic                 cnt_half_c, cnt_last_c;

`ifdef RS232_RX_PARITY_EN
  logic parity_q, parity_d;
  assign par_ok_c = ~^{shift_q, parity_q};
`else
  assign par_ok_c = 1'b1;
`endif

  assign cnt_half_c = (cnt_q == CNT_W'(OVERSAMPLING / 2 - 1));
  assign cnt_last_c = (cnt_q == CNT_W'(OVERSAMPLING - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    data_ready_d  = 1'b0;
    frame_error_d = 1'b0;
    armed_d       = armed_q;
`ifdef RS232_RX_PARITY_EN
    parity_d      = parity_q;
`endif

    // A line seen high re-arms start detection, so a break yields one frame.
    if ((state_q == IDLE) && rx_f) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (baud_tick && armed_q && !rx_f) begin
          state_d = START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (cnt_half_c) begin
            cnt_d = '0;
            if (!rx_f) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_last_c) begin
            cnt_d     = '0;
            shift_d   = {rx_f, shift_q[7:1]};
            bit_idx_d = bit_idx_q + BIT_W'(1);
            if (bit_idx_q == BIT_W'(RS232_DATA_BITS - 1)) begin
`ifdef RS232_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef RS232_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          if (cnt_last_c) begin
            cnt_d    = '0;
            parity_d = rx_f;
            state_d  = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (cnt_last_c) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (rx_f && par_ok_c) begin
              data_d       = shift_q;
              data_ready_d = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle detector: continuous high line while the FSM rests.
    if ((state_q != IDLE) || !rx_f) begin
      idle_cnt_d = '0;
    end else if (baud_tick && (idle_cnt_q != IDLE_W'(IDLE_MAX))) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    idle_d = (idle_cnt_d == IDLE_W'(IDLE_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      armed_q       <= 1'b0;
      idle_cnt_q    <= '0;
      idle_q        <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      data_ready_q  <= data_ready_d;
      frame_error_q <= frame_error_d;
      armed_q       <= armed_d;
      idle_cnt_q    <= idle_cnt_d;
      idle_q        <= idle_d;
`ifdef RS232_RX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign data        = data_q;
  assign data_ready  = data_ready_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);
  assign idle        = idle_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed + randomized bench for rs232_rx; frames are built bit by bit
// from the byte and the expected outcome follows the frame-level rules.
module tb_rs232_rx;

  localparam int unsigned OS        = 8;
  localparam int unsigned DIV       = 4;
  localparam int unsigned IDLE_BITS = 10;
`ifdef RS232_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       data_ready, frame_error, busy, idle;

  int unsigned div_cnt     = 0;
  int unsigned dr_cnt      = 0;
  int unsigned fe_cnt      = 0;
  int unsigned both_cnt    = 0;
  int unsigned busy_clks   = 0;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [7:0]  last_good   = 8'h00;

  rs232_rx #(.OVERSAMPLING(OS), .IDLE_BITS(IDLE_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .data        (data),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .busy        (busy),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_cnt == DIV - 1) begin
      div_cnt   = 0;
      baud_tick = 1'b1;
    end else begin
      div_cnt   = div_cnt + 1;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (data_ready) dr_cnt <= dr_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (data_ready && frame_error) both_cnt <= both_cnt + 1;
    if (busy) busy_clks <= busy_clks + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int unsigned n);
    repeat (n) @(posedge clk iff baud_tick);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pflip);
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(OS);
    end
`ifdef RS232_RX_PARITY_EN
    rxd = (^b) ^ pflip;
    wait_ticks(OS);
`endif
    rxd = stop_bit;
    wait_ticks(OS);
    rxd = 1'b1;
  endtask

  task automatic send_checked(input string tag, input logic [7:0] b,
                              input logic stop_bit, input logic pflip);
    int unsigned dr0, fe0;
    logic ok;
    dr0 = dr_cnt;
    fe0 = fe_cnt;
`ifdef RS232_RX_PARITY_EN
    ok = stop_bit && !pflip;
`else
    ok = stop_bit;
    if (pflip) ok = stop_bit;
`endif
    send_frame(b, stop_bit, pflip);
    wait_ticks(3 * OS);
    if (ok) last_good = b;
    chk({tag, "_ready"}, 32'(dr_cnt - dr0), ok ? 32'd1 : 32'd0);
    chk({tag, "_ferr"},  32'(fe_cnt - fe0), ok ? 32'd0 : 32'd1);
    chk({tag, "_data"},  32'(data), 32'(last_good));
  endtask

  initial begin
    int unsigned dr0, fe0, b0;
    logic [7:0] rb;
    logic       rstop, rflip;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ready", 32'(data_ready), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    wait_ticks((IDLE_BITS + 2) * OS);
    chk("idle_after_rst", 32'(idle), 32'd1);

    // Good 0x55; busy should cover roughly FRAME_BITS-0.5 bit times
    b0 = busy_clks;
    send_checked("b55", 8'h55, 1'b1, 1'b0);
    chk("b55_busy_len",
        32'(((busy_clks - b0) >= (FRAME_BITS - 1) * OS * DIV) &&
            ((busy_clks - b0) <= FRAME_BITS * OS * DIV)), 32'd1);
    wait_ticks(2 * OS);
    chk("idle_early", 32'(idle), 32'd0);
    wait_ticks(7 * OS);
    chk("idle_late", 32'(idle), 32'd1);

    // Two-tick glitch must be filtered out entirely
    dr0 = dr_cnt; fe0 = fe_cnt; b0 = busy_clks;
    rxd = 1'b0;
    wait_ticks(2);
    rxd = 1'b1;
    wait_ticks(2 * OS);
    chk("glitch_busy", 32'(busy_clks - b0), 32'd0);
    chk("glitch_ready", 32'(dr_cnt - dr0), 32'd0);
    chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

    // Bad stop bit
    send_checked("bA3_badstop", 8'hA3, 1'b0, 1'b0);
    wait_ticks(OS);

    // Break: one frame error only, then recovery
    dr0 = dr_cnt; fe0 = fe_cnt;
    rxd = 1'b0;
    wait_ticks(30 * OS);
    rxd = 1'b1;
    wait_ticks(4 * OS);
    chk("break_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("break_ready", 32'(dr_cnt - dr0), 32'd0);
    chk("break_data", 32'(data), 32'(last_good));
    send_checked("b0F", 8'h0F, 1'b1, 1'b0);
    wait_ticks(OS);

    // Reset in the middle of data bit 4 of 0xFF
    dr0 = dr_cnt; fe0 = fe_cnt;
    rxd = 1'b0;
    wait_ticks(OS);
    rxd = 1'b1;
    wait_ticks(4 * OS + OS / 2);
    rst = 1'b1;
    #1;
    last_good = 8'h00;
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(data_ready), 32'd0);
    chk("midrst_ferr", 32'(frame_error), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(8 * OS);
    chk("midrst_no_ready", 32'(dr_cnt - dr0), 32'd0);
    chk("midrst_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    send_checked("b12", 8'h12, 1'b1, 1'b0);
    wait_ticks(OS);

`ifdef RS232_RX_PARITY_EN
    send_checked("par_good", 8'h03, 1'b1, 1'b0);
    wait_ticks(OS);
    send_checked("par_bad", 8'h03, 1'b1, 1'b1);
    wait_ticks(OS);
`endif

    // Randomized frames against the frame-level model
    for (int i = 0; i < 8; i++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
`ifdef RS232_RX_PARITY_EN
      rflip = ($urandom_range(0, 3) == 0);
`else
      rflip = 1'b0;
`endif
      send_checked("rand", rb, rstop, rflip);
      wait_ticks(OS);
    end

    chk("ready_ferr_overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs232_rx.md
# rs232_rx

Oversampling RS-232 receiver that turns the asynchronous `rxd` line into bytes, using the oversampled tick produced by the baud generator (instantiated with `Oversampling = OVERSAMPLING`, `enable` tied high). It sits directly downstream of the baud generator and upstream of the byte consumer (FIFO or command decoder). Frame format: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.

## Interface
- `OVERSAMPLING`, 8: ticks per bit; power of two, ≥ 8; must equal the baud generator's `Oversampling`.
- `IDLE_BITS`, 10: bit-times of continuous idle line before `idle` asserts.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `baud_tick`  in  1  one-`clk` pulse at baud × OVERSAMPLING, from the baud generator.
- `rxd`  in  1  raw serial line, asynchronous, idle high.
- `data`  out  8  last good byte; reset 0x00.
- `data_ready`  out  1  one-cycle pulse when `data` is updated; reset 0.
- `frame_error`  out  1  one-cycle pulse when a bad stop bit (or parity) is detected; reset 0.
- `busy`  out  1  high while a frame is being received (state ≠ IDLE); reset 0.
- `idle`  out  1  high after IDLE_BITS bit-times of idle line; reset 0.

## Operation
- Input conditioning: 2-FF synchronizer on `rxd` (reset 1), then a 2-bit saturating majority counter updated only on `baud_tick`: +1 if synced bit = 1 (saturate at 3), −1 if 0 (saturate at 0). Filtered bit `rx_f` goes 1 at count 3, 0 at count 0, else holds (hysteresis). Reset: count 3, `rx_f` = 1.
- `armed` flag: set when `rx_f` = 1 in IDLE; cleared on entering START. Start detection requires `armed`, so a held-low line (break) produces exactly one frame.
- Sample counter `cnt`, width log2(OVERSAMPLING), advances only on `baud_tick`.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: on tick with `armed` and `rx_f` = 0 → START, `cnt` = 0.
  - START: on tick, if `cnt` = OVERSAMPLING/2−1: `rx_f` = 0 → DATA, `cnt` = 0, bit index = 0; `rx_f` = 1 → IDLE (false start, no output). Else `cnt`++.
  - DATA: on tick, if `cnt` = OVERSAMPLING−1: shift `rx_f` into shift register MSB (right shift), `cnt` = 0; after bit 7 → PARITY or STOP. Else `cnt`++.
  - PARITY: same sampling; store received parity bit → STOP.
  - STOP: same sampling; `rx_f` = 1 and parity ok → `data` ← shift register, `data_ready` pulse; otherwise `frame_error` pulse, `data` unchanged. Always → IDLE.
- Idle counter: in IDLE with `rx_f` = 1, counts ticks, saturating at IDLE_BITS × OVERSAMPLING; `idle` = 1 at saturation. Cleared on `rx_f` = 0 or leaving IDLE.
- `rxd` transitions between ticks affect only the synchronizer; no state change without `baud_tick`.

## Timing
- `rxd` to `rx_f`: 2 `clk` (sync) + filter settling; a low pulse shorter than 3 ticks never reaches `rx_f` = 0.
- Sampling occurs mid-bit: OVERSAMPLING/2 ticks after start detection, then every OVERSAMPLING ticks.
- `data`, `data_ready`, `frame_error` registered: valid on the `clk` edge after the tick that samples the stop bit; pulses last exactly one `clk`.
- `data_ready` and `frame_error` are never high together.
- `rst` asserted mid-frame: immediate return to IDLE, all outputs to reset values, `armed` = 0; the rest of the frame is ignored until the line is seen high.

## Configuration
- `RS232_RX_PARITY_EN` defined: PARITY state compiled in; even parity across 8 data bits + parity bit; mismatch → `frame_error` instead of `data_ready`.
- Not defined: no PARITY state, frame is 10 bits, DATA goes straight to STOP.

## Structure
- Package `rs232_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), `RS232_DATA_BITS` = 8, shared default OVERSAMPLING constant.
- Sub-module `rs232_rx_filter`: synchronizer + majority filter, ports `clk`, `rst`, `baud_tick`, `rxd`, `rx_f`.

## Test plan
- OVERSAMPLING = 8, send 0x55 with a good stop bit → `data` = 0x55, one `data_ready` pulse, `busy` high for ~9.5 bit-times.
- `rxd` low for 2 ticks only → no START entry, no outputs, `busy` stays 0.
- Send 0xA3 with stop bit = 0 after 0x55 → one `frame_error` pulse, `data` stays 0x55.
- Line low for 30 bit-times (break) → exactly one `frame_error`; after line high, 0x0F is received correctly.
- `rst` asserted at data bit 4 of 0xFF → outputs reset immediately, no `data_ready`; next frame 0x12 received.
- With `RS232_RX_PARITY_EN`: 0x03 with parity 0 → `data_ready`; 0x03 with parity 1 → `frame_error`; without the macro, 11 ticks of idle after 10 bits → `idle` = 1 after IDLE_BITS bit-times.
